spi_master: RTL



---
 rtl/spi_master_if.sv | 15 +
 rtl/spi_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// spi_master_if: request bus between a local requester and the SPI initiator.
//   master modport - requester side: drives start/rw/addr/wdata, sees busy/done/rdata
//   slave  modport - spi_master side: the reverse direction
interface spi_master_if;
    logic       start;  // one-cycle request, honoured only while not busy
    logic       rw;     // 1 = read, 0 = write
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;   // one-cycle pulse at transaction end
    logic [7:0] rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master.sv
// spi_master: single-byte SPI initiator (mode 0, MSB first, 16-bit frame).
// A frame is {addr[6:0], rw} followed by wdata (write) or 8 bits captured from miso (read).
// SCLK is divided down from clk: every SCLK phase lasts HALF_PERIOD clk cycles.
//
// Ports:
//   clk_i       FPGA clock, all logic on posedge
//   reset_i     synchronous, active-high reset
//   bus         spi_master_if.slave request bus (start/rw/addr/wdata -> busy/done/rdata)
//   sclk_pin_o  SPI clock, idle low
//   cs_pin_o    chip select, active low
//   mosi_pin_o  master out
//   miso_pin_i  slave out
//   leds_o      debug state; live only when SPI_MASTER_LEDS_EN is defined, else 4'b0000
//
// Optional feature macro: SPI_MASTER_LEDS_EN
//   leds_o = {toggle on each done, last op was read, cs low, busy}
module spi_master #(
    parameter int unsigned HALF_PERIOD = 16  // legal range 2..255
) (
    input  logic         clk_i,
    input  logic         reset_i,
    spi_master_if.slave  bus,
    output logic         sclk_pin_o,
    output logic         cs_pin_o,
    output logic         mosi_pin_o,
    input  logic         miso_pin_i,
    output logic [3:0]   leds_o
);

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StHold, StGap} state_e;

    localparam logic [7:0] PhaseLast = 8'(HALF_PERIOD - 1);

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    // Bits still to be sent after the one currently on mosi; the first bit goes
    // straight to mosi at start, so only 15 remain here.
    logic [14:0] sr_q, sr_d;
    logic        rw_q, rw_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        mosi_q, mosi_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        phase_last;
    logic        start_acc;

    assign phase_last = (phase_q == PhaseLast);
    assign start_acc  = (state_q == StIdle) && bus.start;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        rw_d     = rw_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;

        // Every non-idle state lasts exactly HALF_PERIOD cycles.
        if (state_q != StIdle) begin
            phase_d = phase_last ? 8'd0 : phase_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = StLow;
                    phase_d = 8'd0;
                    bit_d   = 4'd0;
                    rw_d    = bus.rw;
                    // Reads shift out zeros during the data byte.
                    sr_d    = {bus.addr[5:0], bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
                    mosi_d  = bus.addr[6];
                end
            end
            StLow: begin
                if (phase_last) state_d = StHigh;
            end
            StHigh: begin
                if (phase_last) begin
                    // Data byte occupies bits 8..15; sample in the last high cycle.
                    if (bit_q[3]) shadow_d = {shadow_q[6:0], miso_pin_i};
                    if (bit_q != 4'd15) begin
                        state_d = StLow;
                        bit_d   = bit_q + 4'd1;
                        mosi_d  = sr_q[14];
                        sr_d    = {sr_q[13:0], 1'b0};
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (phase_last) state_d = StGap;
            end
            StGap: begin
                if (phase_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (rw_q) rdata_d = shadow_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin levels follow the state being entered so they are registered outputs.
        sclk_d = (state_d == StHigh);
        cs_d   = !((state_d == StLow) || (state_d == StHigh) || (state_d == StHold));
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            phase_q  <= 8'd0;
            bit_q    <= 4'd0;
            sr_q     <= 15'd0;
            rw_q     <= 1'b0;
            shadow_q <= 8'h00;
            rdata_q  <= 8'h00;
            mosi_q   <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            rw_q     <= rw_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            mosi_q   <= mosi_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk_pin_o = sclk_q;
    assign cs_pin_o   = cs_q;
    assign mosi_pin_o = mosi_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;

`ifdef SPI_MASTER_LEDS_EN
    logic led_read_q;
    logic led_tog_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            led_read_q <= 1'b0;
            led_tog_q  <= 1'b0;
        end else begin
            if (start_acc) led_read_q <= bus.rw;
            if (done_d)    led_tog_q  <= ~led_tog_q;
        end
    end

    assign leds_o = {led_tog_q, led_read_q, ~cs_q, busy_q};
`else
    assign leds_o = 4'b0000;
`endif

endmodule
